// File: rtl/nonogram_pkg.sv
// Shared types and board-geometry helpers for the nonogram line engine.
package nonogram_pkg;

   localparam int IDX_MAX_W = 16;

   typedef logic [IDX_MAX_W-1:0] line_idx_t;

   typedef enum logic [1:0] {IDLE, FILTER, COMMIT} state_e;

   // Rows (idx < rows) run along columns and vice versa.
   function automatic int line_len(input line_idx_t idx, input int rows, input int cols);
      return (int'(idx) < rows) ? cols : rows;
   endfunction

   function automatic int cell_pos(input line_idx_t idx, input int i, input int rows, input int cols);
      int ix;
      ix = int'(idx);
      return (ix < rows) ? (ix * cols + i) : (i * cols + (ix - rows));
   endfunction

endpackage

// File: rtl/nonogram_line_filter.sv
// Combinational option check: flags an option that disagrees with any known cell of the line.
module nonogram_line_filter #(
   parameter int LEN = 3
) (
   input  logic [LEN-1:0] opt,
   input  logic [LEN-1:0] line_known,
   input  logic [LEN-1:0] line_assigned,
   input  logic [LEN-1:0] len_mask,
   output logic           contradict,
   output logic [LEN-1:0] opt_masked
);

   assign opt_masked = opt & len_mask;
   assign contradict = |((opt ^ line_assigned) & line_known & len_mask);

endmodule

// File: rtl/nonogram_line_engine.sv
// Per-line pruning engine: filters one line's options, forwards survivors, commits agreed cells.
// One option/cycle, stalls on a full keep register; optional counters under NONOGRAM_STATS_EN.
module nonogram_line_engine
   import nonogram_pkg::*;
#(
   parameter int ROWS      = 3,
   parameter int COLS      = 3,
   parameter int OPT_CNT_W = 7,
   localparam int LEN      = (ROWS > COLS) ? ROWS : COLS,
   localparam int IDX_W    = $clog2(ROWS + COLS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   line_valid,
   output logic                   line_ready,
   input  logic [IDX_W-1:0]       line_idx,
   input  logic [OPT_CNT_W-1:0]   line_cnt,
   input  logic                   opt_valid,
   output logic                   opt_ready,
   input  logic [LEN-1:0]         opt_data,
   output logic                   keep_valid,
   input  logic                   keep_ready,
   output logic [LEN-1:0]         keep_data,
   output logic                   done,
   output logic [IDX_W-1:0]       done_idx,
   output logic [OPT_CNT_W-1:0]   done_cnt,
   output logic                   done_changed,
   output logic                   done_error,
   output logic [ROWS*COLS-1:0]   board_known,
   output logic [ROWS*COLS-1:0]   board_assigned,
   output logic                   solved,
   output logic [31:0]            stat_lines,
   output logic [31:0]            stat_pruned
);

   localparam int NCELL = ROWS * COLS;
   localparam int PW    = (NCELL > 1) ? $clog2(NCELL) : 1;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [OPT_CNT_W-1:0]   rem_q, rem_d, surv_q, surv_d;
   logic [LEN-1:0]         and_q, and_d, or_q, or_d;
   logic                   keep_vld_q, keep_vld_d;
   logic [LEN-1:0]         keep_dat_q, keep_dat_d;
   logic [NCELL-1:0]       known_q, known_d, assigned_q, assigned_d;
   logic                   done_q, done_d, done_changed_q, done_changed_d, done_error_q, done_error_d;
   logic [IDX_W-1:0]       done_idx_q, done_idx_d;
   logic [OPT_CNT_W-1:0]   done_cnt_q, done_cnt_d;

   logic [PW-1:0]          pos [LEN];
   logic [LEN-1:0]         len_mask, line_known, line_assigned, opt_masked;
   logic                   contradict;

   always_comb begin
      len_mask      = '0;
      line_known    = '0;
      line_assigned = '0;
      for (int i = 0; i < LEN; i++) begin
         pos[i] = PW'(cell_pos(line_idx_t'(idx_q), i, ROWS, COLS));
         if (i < line_len(line_idx_t'(idx_q), ROWS, COLS)) begin
            len_mask[i]      = 1'b1;
            line_known[i]    = known_q[pos[i]];
            line_assigned[i] = assigned_q[pos[i]];
         end
      end
   end

   nonogram_line_filter #(.LEN(LEN)) u_filter (
      .opt           (opt_data),
      .line_known    (line_known),
      .line_assigned (line_assigned),
      .len_mask      (len_mask),
      .contradict    (contradict),
      .opt_masked    (opt_masked)
   );

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      rem_d          = rem_q;
      surv_d         = surv_q;
      and_d          = and_q;
      or_d           = or_q;
      keep_vld_d     = keep_vld_q;
      keep_dat_d     = keep_dat_q;
      known_d        = known_q;
      assigned_d     = assigned_q;
      done_d         = 1'b0;
      done_idx_d     = done_idx_q;
      done_cnt_d     = done_cnt_q;
      done_changed_d = done_changed_q;
      done_error_d   = done_error_q;
      line_ready     = 1'b0;
      opt_ready      = 1'b0;

      if (keep_vld_q && keep_ready) keep_vld_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            line_ready = rst_n && !clr;
            if (clr) begin
               known_d    = '0;
               assigned_d = '0;
            end else if (line_valid) begin
               idx_d   = line_idx;
               rem_d   = line_cnt;
               surv_d  = '0;
               and_d   = '1;
               or_d    = '0;
               state_d = (line_cnt == '0) ? COMMIT : FILTER;
            end
         end
         FILTER: begin
            opt_ready = !keep_vld_q || keep_ready;
            if (opt_valid && opt_ready) begin
               rem_d = rem_q - OPT_CNT_W'(1);
               if (!contradict) begin
                  keep_vld_d = 1'b1;
                  keep_dat_d = opt_data;
                  surv_d     = surv_q + OPT_CNT_W'(1);
                  and_d      = and_q & opt_masked;
                  or_d       = or_q | opt_masked;
               end
               if (rem_q == OPT_CNT_W'(1)) state_d = COMMIT;
            end
         end
         COMMIT: begin
            // Wait for the last survivor to leave so the FIFO sees it before done.
            if (!keep_vld_q || keep_ready) begin
               if (surv_q != '0) begin
                  for (int i = 0; i < LEN; i++) begin
                     if (len_mask[i] && and_q[i]) begin
                        known_d[pos[i]]    = 1'b1;
                        assigned_d[pos[i]] = 1'b1;
                     end else if (len_mask[i] && !or_q[i]) begin
                        known_d[pos[i]]    = 1'b1;
                        assigned_d[pos[i]] = 1'b0;
                     end
                  end
               end
               done_d         = 1'b1;
               done_idx_d     = idx_q;
               done_cnt_d     = surv_q;
               done_changed_d = |(known_d & ~known_q);
               done_error_d   = (surv_q == '0);
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         rem_q          <= '0;
         surv_q         <= '0;
         and_q          <= '0;
         or_q           <= '0;
         keep_vld_q     <= 1'b0;
         keep_dat_q     <= '0;
         known_q        <= '0;
         assigned_q     <= '0;
         done_q         <= 1'b0;
         done_idx_q     <= '0;
         done_cnt_q     <= '0;
         done_changed_q <= 1'b0;
         done_error_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         rem_q          <= rem_d;
         surv_q         <= surv_d;
         and_q          <= and_d;
         or_q           <= or_d;
         keep_vld_q     <= keep_vld_d;
         keep_dat_q     <= keep_dat_d;
         known_q        <= known_d;
         assigned_q     <= assigned_d;
         done_q         <= done_d;
         done_idx_q     <= done_idx_d;
         done_cnt_q     <= done_cnt_d;
         done_changed_q <= done_changed_d;
         done_error_q   <= done_error_d;
      end
   end

   assign keep_valid     = keep_vld_q;
   assign keep_data      = keep_dat_q;
   assign done           = done_q;
   assign done_idx       = done_idx_q;
   assign done_cnt       = done_cnt_q;
   assign done_changed   = done_changed_q;
   assign done_error     = done_error_q;
   assign board_known    = known_q;
   assign board_assigned = assigned_q;
   assign solved         = &known_q;

`ifdef NONOGRAM_STATS_EN
   logic [31:0] stat_lines_q, stat_lines_d, stat_pruned_q, stat_pruned_d;

   always_comb begin
      stat_lines_d  = stat_lines_q;
      stat_pruned_d = stat_pruned_q;
      if (state_q == IDLE && clr) begin
         stat_lines_d  = '0;
         stat_pruned_d = '0;
      end else begin
         if (done_d && stat_lines_q != '1) stat_lines_d = stat_lines_q + 32'd1;
         if (state_q == FILTER && opt_valid && opt_ready && contradict && stat_pruned_q != '1)
            stat_pruned_d = stat_pruned_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lines_q  <= '0;
         stat_pruned_q <= '0;
      end else begin
         stat_lines_q  <= stat_lines_d;
         stat_pruned_q <= stat_pruned_d;
      end
   end

   assign stat_lines  = stat_lines_q;
   assign stat_pruned = stat_pruned_q;
`else
   assign stat_lines  = '0;
   assign stat_pruned = '0;
`endif

endmodule
